frame_buffer_reader: RTL and testbench

FRAME_BUFFER_READER -- requirements
Module: frame_buffer_reader

---
 rtl/frame_buffer_reader.sv | 173 +++++++++++++++++
 tb/tb_frame_buffer_reader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader: scans a frame RAM in raster order and streams (x, y, colour)
// pixels through a valid/ready handshake. RAM reads have one cycle of latency; a
// 2-entry output buffer absorbs back-pressure, and a read is only issued when a
// buffer slot is guaranteed for its data.
// Optional feature: define FRAME_BUFFER_READER_CONTINUOUS_EN to rescan frames
// back-to-back after the first start.
module frame_buffer_reader #(
   parameter int unsigned FRAME_W      = 320,
   parameter int unsigned FRAME_H      = 240,
   parameter int unsigned ROW_STRIDE   = 360,
   parameter int unsigned COLOUR_WIDTH = 3
) (
   input  logic                    CLOCK_50,
   input  logic                    resetn,
   input  logic                    start,
   output logic [16:0]             rd_address,
   input  logic [COLOUR_WIDTH-1:0] rd_q,
   output logic [8:0]              out_x,
   output logic [7:0]              out_y,
   output logic [COLOUR_WIDTH-1:0] out_colour,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    busy,
   output logic                    frame_done
);

`ifdef FRAME_BUFFER_READER_CONTINUOUS_EN
   localparam bit Continuous = 1'b1;
`else
   localparam bit Continuous = 1'b0;
`endif

   localparam logic [8:0]  XLast  = 9'(FRAME_W - 1);
   localparam logic [7:0]  YLast  = 8'(FRAME_H - 1);
   localparam logic [16:0] Stride = 17'(ROW_STRIDE);

   typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

   typedef struct packed {
      logic                    last;
      logic [7:0]              y;
      logic [8:0]              x;
      logic [COLOUR_WIDTH-1:0] colour;
   } pix_t;

   state_e      state_q;
   logic [8:0]  x_q;
   logic [7:0]  y_q;
   logic [16:0] row_base_q;
   logic [16:0] addr_q;

   // Tag of the read whose data appears on rd_q this cycle
   logic        rd_pend_q;
   logic        rd_last_q;
   logic [8:0]  rd_x_q;
   logic [7:0]  rd_y_q;

   pix_t        head_q, tail_q, head_d, tail_d, arrive;
   logic        head_v_q, tail_v_q, head_v_d, tail_v_d;
   logic        busy_q, done_q;

   logic        pop, issue, issue_last;
   logic [2:0]  occ;

   assign rd_address = addr_q;
   assign out_x      = head_q.x;
   assign out_y      = head_q.y;
   assign out_colour = head_q.colour;
   assign out_valid  = head_v_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

   // Issue decision: occupancy after this edge (buffered + in flight) must leave room
   always_comb begin
      pop        = head_v_q & out_ready;
      occ        = 3'(head_v_q) + 3'(tail_v_q) + 3'(rd_pend_q) - 3'(pop);
      issue_last = (x_q == XLast) && (y_q == YLast);
      issue      = (occ <= 3'd1) && (((state_q == StIdle) && start) || (state_q == StScan));
   end

   // Output buffer next state: pop from head, then land returning RAM data
   always_comb begin
      head_d   = head_q;
      tail_d   = tail_q;
      head_v_d = head_v_q;
      tail_v_d = tail_v_q;
      arrive   = '{last: rd_last_q, y: rd_y_q, x: rd_x_q, colour: rd_q};
      if (pop) begin
         if (tail_v_q) head_d = tail_q;
         head_v_d = tail_v_q;
         tail_v_d = 1'b0;
      end
      if (rd_pend_q) begin
         if (!head_v_d) begin
            head_d   = arrive;
            head_v_d = 1'b1;
         end else begin
            tail_d   = arrive;
            tail_v_d = 1'b1;
         end
      end
   end

   // Scan counters, read pipeline, output buffer and control FSM
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state_q    <= StIdle;
         x_q        <= '0;
         y_q        <= '0;
         row_base_q <= '0;
         addr_q     <= '0;
         rd_pend_q  <= 1'b0;
         rd_last_q  <= 1'b0;
         rd_x_q     <= '0;
         rd_y_q     <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         head_v_q   <= 1'b0;
         tail_v_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         head_v_q  <= head_v_d;
         tail_v_q  <= tail_v_d;
         done_q    <= pop & head_q.last;
         rd_pend_q <= issue;

         if (issue) begin
            rd_last_q <= issue_last;
            rd_x_q    <= x_q;
            rd_y_q    <= y_q;
            if (x_q == XLast) begin
               x_q <= '0;
               if (issue_last) begin
                  y_q        <= '0;
                  row_base_q <= '0;
                  addr_q     <= '0;
               end else begin
                  y_q        <= y_q + 8'd1;
                  row_base_q <= row_base_q + Stride;
                  addr_q     <= row_base_q + Stride;
               end
            end else begin
               x_q    <= x_q + 9'd1;
               addr_q <= addr_q + 17'd1;
            end
         end

         unique case (state_q)
            StIdle: begin
               // The idle address is (0,0), so the start edge itself issues the first read
               if (issue) begin
                  state_q <= (issue_last && !Continuous) ? StDrain : StScan;
                  busy_q  <= 1'b1;
               end
            end
            StScan: begin
               if (issue && issue_last && !Continuous) state_q <= StDrain;
            end
            StDrain: begin
               if (pop && head_q.last) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Directed bench for frame_buffer_reader. A reduced frame keeps run time short;
// a second, default-sized instance checks the full-size address arithmetic.
module tb_frame_buffer_reader;

   localparam int W = 24;
   localparam int H = 16;
   localparam int S = 28;
   localparam int N = W * H;

   logic        CLOCK_50;
   logic        resetn, start, out_ready;
   logic [16:0] rd_address;
   logic [2:0]  rd_q, out_colour;
   logic [8:0]  out_x;
   logic [7:0]  out_y;
   logic        out_valid, busy, frame_done;

   logic        start_d, ready_d;
   logic [16:0] rd_address_d;
   logic [2:0]  rd_q_d, out_colour_d;
   logic [8:0]  out_x_d;
   logic [7:0]  out_y_d;
   logic        out_valid_d, busy_d, frame_done_d;

   int n_cmp = 0;
   int n_err = 0;
   int idx, fd_cnt;
   bit last_final;

   frame_buffer_reader #(
      .FRAME_W(W), .FRAME_H(H), .ROW_STRIDE(S), .COLOUR_WIDTH(3)
   ) u_dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .rd_address(rd_address),
      .rd_q(rd_q), .out_x(out_x), .out_y(out_y), .out_colour(out_colour),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
   );

   frame_buffer_reader u_dut_def (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start_d), .rd_address(rd_address_d),
      .rd_q(rd_q_d), .out_x(out_x_d), .out_y(out_y_d), .out_colour(out_colour_d),
      .out_valid(out_valid_d), .out_ready(ready_d), .busy(busy_d), .frame_done(frame_done_d)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   function automatic logic [2:0] ram_word(input logic [16:0] a);
      return a[2:0] ^ a[5:3] ^ a[8:6] ^ a[11:9] ^ 3'(a[16:12]);
   endfunction

   // Synchronous RAM models: data one cycle after address
   always @(posedge CLOCK_50) begin
      rd_q   <= ram_word(rd_address);
      rd_q_d <= ram_word(rd_address_d);
   end

   function automatic logic [31:0] exp_pix(input int i);
      int ex, ey;
      ex = i % W;
      ey = i / W;
      return {12'b0, 8'(ey), 9'(ex), ram_word(17'(ey * S + ex))};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock: scoreboard transfers at the negedge, return 1ns after the next posedge
   task automatic tick();
      @(negedge CLOCK_50);
      if (frame_done === 1'b1) begin
         fd_cnt++;
         check_eq("frame_done_after_last", 32'(last_final), 32'd1);
      end
      last_final = 1'b0;
      if (out_valid === 1'b1 && out_ready) begin
         check_eq("pixel", {12'b0, out_y, out_x, out_colour}, exp_pix(idx % N));
         last_final = ((idx % N) == N - 1);
         idx++;
      end
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_rd_address"}, 32'(rd_address), 32'd0);
      check_eq({tag, "_out_x"}, 32'(out_x), 32'd0);
      check_eq({tag, "_out_y"}, 32'(out_y), 32'd0);
      check_eq({tag, "_out_colour"}, 32'(out_colour), 32'd0);
      check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_frame_done"}, 32'(frame_done), 32'd0);
   endtask

   // mode 0: ready high, 1: random ready, 2: stall at (5,0), 3: start at (10,7),
   // 4: reset at (17,11)
   task automatic run_frame(input int mode);
      int t, stall;
      bit pulsed, done;
      idx = 0; fd_cnt = 0; stall = 0; pulsed = 0; done = 0; last_final = 0;
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      t = 1;
      check_eq("busy_after_start", 32'(busy), 32'd1);
      check_eq("no_valid_cycle1", 32'(out_valid), 32'd0);
      while (!done && idx < N && t < 4 * N + 40) begin
         case (mode)
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin
               if (out_valid && out_x == 9'd5 && out_y == 8'd0 && stall < 10) begin
                  out_ready = 1'b0;
                  check_eq("stall_hold", {out_valid, 11'b0, out_y, out_x, out_colour},
                           exp_pix(5) | 32'h8000_0000);
                  stall++;
               end else out_ready = 1'b1;
            end
            3: begin
               if (out_valid && out_x == 9'd10 && out_y == 8'd7 && !pulsed) begin
                  start = 1'b1;
                  pulsed = 1'b1;
               end else start = 1'b0;
            end
            4: begin
               if (out_valid && out_x == 9'd17 && out_y == 8'd11) begin
                  out_ready = 1'b0;
                  resetn = 1'b0;
                  tick();
                  check_all_zero("midframe_reset");
                  resetn = 1'b1;
                  out_ready = 1'b1;
                  repeat (3) begin
                     tick();
                     check_eq("no_valid_after_reset", 32'(out_valid), 32'd0);
                  end
                  done = 1'b1;
               end
            end
            default: out_ready = 1'b1;
         endcase
         if (!done) begin
            tick();
            t++;
            if (mode == 0 && t == 2)
               check_eq("first_valid_cycle2", {out_valid, 11'b0, out_y, out_x, out_colour},
                        exp_pix(0) | 32'h8000_0000);
            if (mode == 0 && t == W + 1)
               check_eq("rd_addr_1_1", 32'(rd_address), 32'(S + 1));
         end
      end
      start = 1'b0;
      if (mode != 4) begin
         check_eq("frame_xfers", 32'(idx), 32'(N));
         if (mode == 0) check_eq("frame_cycles", 32'(t), 32'(N + 2));
         if (mode == 2) check_eq("stall_cycles", 32'(stall), 32'd10);
         out_ready = 1'b1;
         repeat (4) tick();
         check_eq("frame_done_count", 32'(fd_cnt), 32'd1);
         check_eq("busy_low_after", 32'(busy), 32'd0);
         check_eq("idle_no_valid", 32'(out_valid), 32'd0);
      end
   endtask

   initial begin
      resetn = 1'b0; start = 1'b1; out_ready = 1'b1; start_d = 1'b1; ready_d = 1'b1;
      idx = 0; fd_cnt = 0; last_final = 0;
      // Reset with start held high: start must not take effect
      repeat (2) tick();
      check_all_zero("reset");
      resetn = 1'b1; start = 1'b0; start_d = 1'b0;
      repeat (2) tick();
      check_eq("start_in_reset_ignored", 32'(busy), 32'd0);
      check_eq("start_in_reset_ignored_def", 32'(busy_d), 32'd0);

      // Default-size instance: latency and address of (1,1)
      start_d = 1'b1;
      tick();
      start_d = 1'b0;
      check_eq("def_valid_c1", 32'(out_valid_d), 32'd0);
      tick();
      check_eq("def_valid_c2", 32'(out_valid_d), 32'd1);
      repeat (319) tick();
      check_eq("def_rd_addr_1_1", 32'(rd_address_d), 32'd361);
      repeat (2) tick();
      check_eq("def_pixel_1_1", {out_valid_d, 11'b0, out_y_d, out_x_d, out_colour_d},
               {1'b1, 11'b0, 8'd1, 9'd1, ram_word(17'd361)});

`ifdef FRAME_BUFFER_READER_CONTINUOUS_EN
      idx = 0; fd_cnt = 0; last_final = 0;
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (2 * N + 2) tick();
      check_eq("cont_xfers_no_gap", 32'(idx), 32'(2 * N + 1));
      check_eq("cont_frame_done_count", 32'(fd_cnt), 32'd2);
      check_eq("cont_busy_high", 32'(busy), 32'd1);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      check_all_zero("cont_reset");
`else
      run_frame(0);
      run_frame(1);
      run_frame(2);
      run_frame(3);
      run_frame(4);
      run_frame(0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
